// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of in-flight branch predictions, checked
// against the EX outcome. A mispredict flushes the front end, redirects the PC
// and clears every younger entry; every resolve trains the 2-bit predictor.
module branch_resolve_unit #(
    parameter int DEPTH     = 2,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_valid_i,
    input  logic             push_pred_i,
    input  logic [31:0]      push_pc_i,
    input  logic [31:0]      push_imm_i,
    output logic             push_ready_o,
    input  logic             res_valid_i,
    input  logic             res_taken_i,
    output logic             upd_valid_o,
    output logic             upd_taken_o,
    output logic             flush_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o,
    output logic             err_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int REC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef struct packed {
        logic        pred;
        logic [31:0] pc;
        logic [31:0] target;
    } br_entry_t;

    typedef enum logic {IDLE, RECOVER} state_t;

    br_entry_t        ent_q [DEPTH];
    logic [PTR_W-1:0] head_ptr, tail_ptr;
    logic [OCC_W-1:0] occ;
    state_t           state;
    logic [REC_W-1:0] rec_cnt;

    br_entry_t        head;
    logic             idle, empty, full;
    logic             res_fire, mispred, push_fire, push_err, res_err;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Queue status and the accept/error decisions for this cycle
    always_comb begin
        idle      = (state == IDLE);
        empty     = (occ == '0);
        full      = (occ == OCC_W'(DEPTH));
        head      = ent_q[head_ptr];
        res_fire  = idle & res_valid_i & ~empty;
        mispred   = res_fire & (res_taken_i != head.pred);
        // A correct resolve frees the head slot, so a full queue can still take the push;
        // a push alongside a mispredict is younger than the branch and is dropped.
        push_fire = idle & push_valid_i & ~mispred & (~full | res_fire);
        push_err  = idle & push_valid_i & full & ~res_fire;
        res_err   = idle & res_valid_i & empty;
    end

    assign push_ready_o = idle & ~full;

    // Entry storage; the target is precomputed so resolve only has to pick a PC
    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            ent_q[tail_ptr] <= '{pred:   push_pred_i,
                                 pc:     push_pc_i,
                                 target: push_pc_i + (push_imm_i << 1)};
        end
    end

    // Head/tail pointers and occupancy; a mispredict squashes the whole queue
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            occ      <= '0;
        end else if (mispred) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            occ      <= '0;
        end else begin
            if (res_fire)  head_ptr <= ptr_inc(head_ptr);
            if (push_fire) tail_ptr <= ptr_inc(tail_ptr);
            case ({push_fire, res_fire})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Recovery FSM with registered train, flush and redirect outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            rec_cnt          <= '0;
            upd_valid_o      <= 1'b0;
            upd_taken_o      <= 1'b0;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            upd_valid_o      <= res_fire;
            upd_taken_o      <= res_fire & res_taken_i;
            redirect_valid_o <= mispred;
            if (mispred)
                redirect_pc_o <= res_taken_i ? head.target : head.pc + 32'd4;
            case (state)
                IDLE: begin
                    if (mispred) begin
                        state   <= RECOVER;
                        flush_o <= 1'b1;
                        rec_cnt <= REC_W'(FLUSH_CYC - 1);
                    end
                end
                RECOVER: begin
                    if (rec_cnt == '0) begin
                        state   <= IDLE;
                        flush_o <= 1'b0;
                    end else begin
                        rec_cnt <= rec_cnt - REC_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics counters and the sticky protocol-error flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
            err_o         <= 1'b0;
        end else begin
            if (res_fire && branch_cnt_o != '1)
                branch_cnt_o <= branch_cnt_o + CNT_W'(1);
            if (mispred && mispred_cnt_o != '1)
                mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
            if (push_err || res_err)
                err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit. A queue-based reference
// model predicts each resolve; a monitor checks every train pulse against it.
// A second instance with 4-bit counters exercises counter saturation.
module tb_branch_resolve_unit;

    localparam int DEPTH = 2;
    localparam int FLUSH = 2;
    localparam int SAT2  = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pv = 1'b0, pp = 1'b0, rv = 1'b0, rt = 1'b0;
    logic [31:0] ppc = '0, pimm = '0;

    logic        ready, upd_v, upd_t, flush, rdv, err;
    logic [31:0] rpc, bcnt, mcnt;
    logic        ready2, upd_v2, upd_t2, flush2, rdv2, err2;
    logic [31:0] rpc2;
    logic [3:0]  bcnt2, mcnt2;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .push_valid_i(pv), .push_pred_i(pp),
        .push_pc_i(ppc), .push_imm_i(pimm), .push_ready_o(ready),
        .res_valid_i(rv), .res_taken_i(rt), .upd_valid_o(upd_v), .upd_taken_o(upd_t),
        .flush_o(flush), .redirect_valid_o(rdv), .redirect_pc_o(rpc),
        .branch_cnt_o(bcnt), .mispred_cnt_o(mcnt), .err_o(err));

    branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH), .CNT_W(4)) dut2 (
        .clk_i(clk), .rst_i(rst), .push_valid_i(pv), .push_pred_i(pp),
        .push_pc_i(ppc), .push_imm_i(pimm), .push_ready_o(ready2),
        .res_valid_i(rv), .res_taken_i(rt), .upd_valid_o(upd_v2), .upd_taken_o(upd_t2),
        .flush_o(flush2), .redirect_valid_o(rdv2), .redirect_pc_o(rpc2),
        .branch_cnt_o(bcnt2), .mispred_cnt_o(mcnt2), .err_o(err2));

    typedef struct {
        logic        pred;
        logic [31:0] pc;
        logic [31:0] imm;
    } mentry_t;

    typedef struct {
        logic        taken;
        logic        mis;
        logic [31:0] rpc;
        int          bc;
        int          mc;
    } exp_t;

    mentry_t mq[$];
    exp_t    sb[$];
    int      m_rec = 0;
    logic    m_err = 1'b0;
    int      m_bc = 0, m_mc = 0;
    int      checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Train pulses are matched in order against the model's expected resolves
    always @(negedge clk) begin
        if (upd_v === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_upd", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("upd_taken", upd_t, e.taken);
                chk("redirect_valid", rdv, e.mis);
                if (e.mis) chk("redirect_pc", rpc, e.rpc);
                chk("branch_cnt", bcnt, e.bc);
                chk("mispred_cnt", mcnt, e.mc);
                chk("branch_cnt_sat", bcnt2, sat(e.bc, SAT2));
                chk("mispred_cnt_sat", mcnt2, sat(e.mc, SAT2));
                chk("upd_valid2", upd_v2, 1);
            end
        end else begin
            chk("redirect_idle", rdv, 0);
        end
    end

    // One stimulus cycle: check level outputs, drive inputs, advance the model
    task automatic cyc(input logic v, input logic pred, input logic [31:0] pc,
                       input logic [31:0] imm, input logic r, input logic t);
        @(negedge clk);
        chk("push_ready", ready, (m_rec == 0 && mq.size() < DEPTH));
        chk("flush", flush, m_rec > 0);
        chk("err", err, m_err);
        chk("flush2", flush2, m_rec > 0);
        pv = v; pp = pred; ppc = pc; pimm = imm; rv = r; rt = t;
        if (m_rec > 0) begin
            m_rec--;
        end else begin
            logic mis;
            mis = 1'b0;
            if (r) begin
                if (mq.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    mentry_t h;
                    exp_t    e;
                    h = mq.pop_front();
                    mis = (t != h.pred);
                    m_bc++;
                    if (mis) m_mc++;
                    e.taken = t;
                    e.mis   = mis;
                    e.rpc   = t ? h.pc + h.imm * 2 : h.pc + 4;
                    e.bc    = m_bc;
                    e.mc    = m_mc;
                    sb.push_back(e);
                end
            end
            if (mis) begin
                mq.delete();
                m_rec = FLUSH;
            end else if (v) begin
                if (mq.size() < DEPTH) mq.push_back('{pred, pc, imm});
                else m_err = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pv = 0; rv = 0; pp = 0; rt = 0; ppc = '0; pimm = '0;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_rec = 0; m_err = 1'b0; m_bc = 0; m_mc = 0;
        chk("rst_flush", flush, 0);
        chk("rst_ready", ready, 1);
        chk("rst_err", err, 0);
        chk("rst_upd", upd_v, 0);
        chk("rst_redirect", rdv, 0);
        chk("rst_redirect_pc", rpc, 0);
        chk("rst_branch_cnt", bcnt, 0);
        chk("rst_mispred_cnt", mcnt, 0);
        chk("rst_branch_cnt2", bcnt2, 0);
    endtask

    initial begin
        do_reset();
        // correct taken prediction
        cyc(1, 1, 32'h100, 32'h8, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        idle(2);
        // taken predicted, not taken actual -> fallthrough
        cyc(1, 1, 32'h100, 32'h8, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle(4);
        // backward branch predicted not-taken, actually taken
        cyc(1, 0, 32'h200, 32'hFFFF_FFFC, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        idle(4);
        // fill, blocked push, forced push -> err, full-queue push + correct resolve
        cyc(1, 1, 32'h300, 32'h10, 0, 0);
        cyc(1, 1, 32'h310, 32'h10, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'h320, 32'h10, 0, 0);
        cyc(1, 1, 32'h330, 32'h10, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        idle(2);
        // mispredict squashes the queued entry and the same-cycle push
        do_reset();
        cyc(1, 0, 32'h400, 32'h20, 0, 0);
        cyc(1, 1, 32'h404, 32'h20, 0, 0);
        cyc(1, 1, 32'h408, 32'h20, 1, 1);
        idle(3);
        cyc(0, 0, 0, 0, 1, 1);
        idle(2);
        // reset in the middle of recovery
        do_reset();
        cyc(1, 1, 32'h500, 32'h4, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        do_reset();
        // drive the 4-bit counters past saturation
        for (int i = 0; i < 20; i++) cyc(1, 1, 32'h600 + i * 4, 32'h2, i > 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        idle(2);
        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic v, r;
            if ($urandom_range(0, 299) == 0) do_reset();
            if (m_rec == 0 && mq.size() < DEPTH) v = $urandom_range(0, 1);
            else v = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 2) == 0);
            if (mq.size() == 0 && $urandom_range(0, 7) != 0) r = 1'b0;
            cyc(v, $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC,
                32'($signed(12'($urandom))), r, $urandom_range(0, 1));
        end
        idle(5);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
